// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: prioritised interrupt arbiter with a claim/complete handshake
// and a small word-addressed register interface.
module interrupt_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [3:0]         bus_addr,
  input  logic               bus_wen,
  input  logic               bus_ren,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               external_interrupt
);

  localparam logic [3:0] ADDR_PENDING   = 4'h0;
  localparam logic [3:0] ADDR_ENABLE    = 4'h1;
  localparam logic [3:0] ADDR_THRESHOLD = 4'h2;
  localparam logic [3:0] ADDR_CLAIM     = 4'h3;
  localparam logic [3:0] ADDR_EDGE_MODE = 4'h4;

  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] in_service_r;
  logic [NUM_SRC-1:0] prev_r;
  logic [NUM_SRC-1:0] enable_r;
  logic [NUM_SRC-1:0] edge_mode_r;
  logic [PRIO_W-1:0]  threshold_r;
  logic [PRIO_W-1:0]  prio_r [NUM_SRC];
  logic [3:0]         best_id_r;

  logic               read_s;
  logic               claim_s;
  logic               complete_s;
  logic [NUM_SRC-1:0] claim_vec_s;
  logic [NUM_SRC-1:0] complete_vec_s;
  logic [NUM_SRC-1:0] level_set_s;
  logic [NUM_SRC-1:0] edge_set_s;
  logic [NUM_SRC-1:0] pending_next_s;
  logic [NUM_SRC-1:0] in_service_next_s;
  logic [3:0]         best_id_next_s;
  logic [PRIO_W-1:0]  best_prio_s;
  logic [31:0]        prio_rd_s;
  logic [31:0]        rdata_next_s;

  // A simultaneous write strobe turns the access into a write only.
  assign read_s     = bus_ren & ~bus_wen;
  assign claim_s    = read_s & (bus_addr == ADDR_CLAIM) & (best_id_r != 4'd0);
  assign complete_s = bus_wen & (bus_addr == ADDR_CLAIM);

  // One-hot decode of the source being claimed and the source being completed
  always_comb begin
    claim_vec_s    = {NUM_SRC{1'b0}};
    complete_vec_s = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec_s[i]    = claim_s & (best_id_r == 4'(i + 1));
      complete_vec_s[i] = complete_s & (bus_wdata[3:0] == 4'(i + 1));
    end
  end

  // Edge sets beat a coincident claim; level sets are held off while in service.
  assign level_set_s       = ~edge_mode_r & irq_src & ~in_service_r & ~claim_vec_s;
  assign edge_set_s        = edge_mode_r & irq_src & ~prev_r;
  assign pending_next_s    = level_set_s | edge_set_s | (pending_r & ~claim_vec_s);
  assign in_service_next_s = (in_service_r | claim_vec_s) & ~complete_vec_s;

  // Pick the highest-priority eligible source; strict compare keeps the lowest ID on ties
  always_comb begin
    best_id_next_s = 4'd0;
    best_prio_s    = {PRIO_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_r[i] && enable_r[i] && (prio_r[i] != {PRIO_W{1'b0}}) &&
          (prio_r[i] > threshold_r) && (prio_r[i] > best_prio_s)) begin
        best_id_next_s = 4'(i + 1);
        best_prio_s    = prio_r[i];
      end else begin
        best_id_next_s = best_id_next_s;
        best_prio_s    = best_prio_s;
      end
    end
  end

  // Read data mux; unmapped addresses and absent priority slots read as zero
  always_comb begin
    prio_rd_s = 32'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      prio_rd_s = (bus_addr == 4'(8 + i)) ? 32'(prio_r[i]) : prio_rd_s;
    end
    case (bus_addr)
      ADDR_PENDING:   rdata_next_s = 32'(pending_r);
      ADDR_ENABLE:    rdata_next_s = 32'(enable_r);
      ADDR_THRESHOLD: rdata_next_s = 32'(threshold_r);
      ADDR_CLAIM:     rdata_next_s = 32'(best_id_r);
      ADDR_EDGE_MODE: rdata_next_s = 32'(edge_mode_r);
      default:        rdata_next_s = prio_rd_s;
    endcase
  end

  // Interrupt tracking state, arbitration result and registered read data
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_r             <= {NUM_SRC{1'b0}};
      pending_r          <= {NUM_SRC{1'b0}};
      in_service_r       <= {NUM_SRC{1'b0}};
      best_id_r          <= 4'd0;
      external_interrupt <= 1'b0;
      bus_rdata          <= 32'd0;
    end else begin
      prev_r             <= irq_src;
      pending_r          <= pending_next_s;
      in_service_r       <= in_service_next_s;
      best_id_r          <= claim_s ? 4'd0 : best_id_next_s;
      external_interrupt <= ~claim_s & (best_id_next_s != 4'd0);
      if (read_s) begin
        bus_rdata <= rdata_next_s;
      end
    end
  end

  // Software-visible configuration registers
  always_ff @(posedge clock) begin
    if (reset) begin
      enable_r    <= {NUM_SRC{1'b0}};
      threshold_r <= {PRIO_W{1'b0}};
      edge_mode_r <= {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_r[i] <= {PRIO_W{1'b0}};
      end
    end else if (bus_wen) begin
      case (bus_addr)
        ADDR_ENABLE:    enable_r    <= bus_wdata[NUM_SRC-1:0];
        ADDR_THRESHOLD: threshold_r <= bus_wdata[PRIO_W-1:0];
        ADDR_EDGE_MODE: edge_mode_r <= bus_wdata[NUM_SRC-1:0];
        default:        enable_r    <= enable_r;
      endcase
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus_addr == 4'(8 + i)) begin
          prio_r[i] <= bus_wdata[PRIO_W-1:0];
        end
      end
    end
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, 8, number of interrupt sources (1..8); source i has ID i+1, and ID 0 means "none".
REQ-002 SHALL have parameter PRIO_W, 3, width of the priority and threshold fields.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port irq_src  input  NUM_SRC  raw interrupt lines, synchronous to clock.
REQ-006 SHALL have port bus_addr  input  4  word address.
REQ-007 SHALL have ports bus_wen and bus_ren, each input 1, write and read strobe.
REQ-008 SHALL have port bus_wdata  input  32  write data.
REQ-009 SHALL have port bus_rdata  output  32  registered read data.
REQ-010 SHALL have port external_interrupt  output  1  registered; drives the CSR file's external_interrupt input (mip[11]).

Function
REQ-011 SHALL decode the word-address map as follows:
- 0x0 PENDING: read-only.
- 0x1 ENABLE: read/write, bits [NUM_SRC-1:0].
- 0x2 THRESHOLD: read/write, bits [PRIO_W-1:0].
- 0x3 CLAIM: a read claims; a write completes.
- 0x4 EDGE_MODE: read/write; 1 = rising-edge source, 0 = level source.
- 0x8+i PRIORITY[i]: read/write, bits [PRIO_W-1:0].
REQ-012 SHALL return 0 on reads of unmapped addresses and of PRIORITY slots with i >= NUM_SRC.
REQ-013 SHALL ignore writes to unmapped addresses and to PENDING.
REQ-014 SHALL update bus_rdata only at an edge where bus_ren=1, and hold it otherwise.
REQ-015 SHALL treat bus_wen=1 with bus_ren=1 as a write only: the read is dropped and bus_rdata holds.
REQ-016 SHALL register irq_src into a previous-value register every cycle.
REQ-017 SHALL set pending for a level source i when irq_src[i]=1 and in_service[i]=0, and SHALL not set it in a cycle where source i is being claimed.
REQ-018 SHALL set pending for an edge source i when irq_src[i]=1 and prev[i]=0, regardless of in_service.
REQ-019 SHALL let the set win over the claim clear when an edge-source set coincides with a claim of the same source.
REQ-020 SHALL drop an edge arriving while pending is already 1, with no event counting.
REQ-021 SHALL NOT clear pending when its enable bit is cleared.
REQ-022 SHALL treat source i as eligible when pending=1, enable=1, priority != 0 and priority > threshold.
REQ-023 SHALL register best_id each edge: the eligible source with the highest priority, ties broken by lowest ID, or 0 if none is eligible.
REQ-024 SHALL register external_interrupt on the same edge as (next best_id != 0).
REQ-025 SHALL give a latency of two edges from irq_src assertion to external_interrupt=1: edge 1 sets pending, edge 2 sets best_id and external_interrupt.
REQ-026 SHALL make THRESHOLD, PRIORITY and ENABLE writes take effect at the next arbitration edge, so external_interrupt changes one edge after the write edge.
REQ-027 SHALL, on a claim read (bus_ren, addr 0x3), set bus_rdata to the current best_id.
REQ-028 SHALL, when a claim read returns best_id != 0, clear pending and set in_service for that source on the same edge.
REQ-029 SHALL force best_id and external_interrupt to 0 on the claim edge; arbitration resumes at the following edge.
REQ-030 SHALL return 0 and change no state on a claim read when best_id = 0.
REQ-031 SHALL, on a complete write (bus_wen, addr 0x3) with bus_wdata[3:0] = ID in 1..NUM_SRC, clear in_service[ID-1].
REQ-032 SHALL ignore a complete write with ID out of range, and treat completing a source that is not in service as a no-op.
REQ-033 SHALL report PENDING reads as the pending vector zero-extended to 32 bits.

Reset
REQ-034 SHALL, at any edge with reset=1, clear pending, in_service, prev, ENABLE, THRESHOLD, EDGE_MODE, all PRIORITY, best_id, bus_rdata and external_interrupt to 0.
REQ-035 SHALL ignore bus strobes in cycles with reset=1.
REQ-036 SHALL, when reset is asserted mid-claim, return the block to the reset state, discarding in-service state.
REQ-037 SHALL treat an edge source high at reset release as a rising edge, since prev resets to 0.

Verification
REQ-038 SHALL cover level round trip: PRIORITY[0]=3, ENABLE=0x01, irq_src[0]=1 held.
- external_interrupt=1 two edges later; claim returns 1; external_interrupt=0 next cycle and stays 0.
- Complete with 1: pending set one edge later, external_interrupt=1 the edge after.
REQ-039 SHALL cover tie-break: PRIORITY[2]=PRIORITY[5]=5, ENABLE=0x24, both sources pulsed high.
- First claim returns 3, second claim returns 6, third returns 0 with external_interrupt=0.
REQ-040 SHALL cover threshold: PRIORITY[1]=2, THRESHOLD=2, ENABLE=0x02, irq_src[1]=1.
- external_interrupt stays 0; after writing THRESHOLD=1 it goes to 1 one edge later; claim returns 2.
REQ-041 SHALL cover edge mode: EDGE_MODE=0x08, ENABLE=0x08, PRIORITY[3]=1.
- Two 1-cycle pulses before any claim: PENDING reads 0x08, claim returns 4, PENDING reads 0.
- A pulse while in service: PENDING reads 0x08 again.
REQ-042 SHALL cover no-ops: claim with nothing pending returns 0 with no state change; complete with ID 9 or 0 leaves in_service unchanged.
REQ-043 SHALL cover mid-operation reset: claim source 0, then assert reset for one cycle.
- external_interrupt=0, PENDING=0, ENABLE=0, bus_rdata=0.
- irq_src[0]=1 does not interrupt until re-enabled and re-prioritised.
